alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Upstream issue stage for the combinational ALU.
- Holds a small 32-bit register bank and accepts one instruction at a time over a valid/ready handshake (op, two source indices, one destination index).
- Drives A_bus, B_bus and op into the ALU, samples C_bus and Z, and writes the result back to the bank.
- Multi-cycle and non-pipelined: one instruction in flight at a time.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU buses.
- OP_W, 4, ALU opcode width.
- NREGS, 8, number of bank registers; power of two, at least 2.
- RA_W, $clog2(NREGS), register index width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_op  in  OP_W  ALU opcode.
- instr_ra  in  RA_W  source A index.
- instr_rb  in  RA_W  source B index.
- instr_rd  in  RA_W  destination index.
- ld_en  in  1  external register load strobe.
- ld_addr  in  RA_W  load index.
- ld_data  in  DATA_W  load value.
- A_bus  out  DATA_W  ALU operand A, registered.
- B_bus  out  DATA_W  ALU operand B, registered.
- op  out  OP_W  ALU opcode, registered.
- C_bus  in  DATA_W  ALU result.
- Z  in  1  ALU zero flag.
- result  out  DATA_W  last written-back result.
- z_flag  out  1  Z sampled with the last result.
- done  out  1  one-cycle pulse at writeback.

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; A_bus, B_bus, op, result all 0; z_flag=0; done=0; all bank registers 0. Reset asserted mid-instruction abandons the instruction with no writeback.
- Register 0: reads always return 0; writes to index 0, by load or writeback, are discarded.
- FSM states: IDLE, OPERAND, EXECUTE, WRITEBACK.
- IDLE:
  - instr_ready=1 in IDLE only.
  - On instr_valid && instr_ready, latch op, ra, rb and rd, then go to OPERAND.
- OPERAND:
  - Read bank[ra] and bank[rb].
  - At the end of this cycle, A_bus and B_bus take the read values and op takes the latched opcode.
  - Go to EXECUTE.
- EXECUTE:
  - The ALU settles combinationally.
  - At the end of this cycle, result takes C_bus and z_flag takes Z.
  - Go to WRITEBACK.
- WRITEBACK:
  - done=1 for exactly this cycle.
  - At the end of the cycle, bank[rd] takes result.
  - Go to IDLE.
- Timing:
  - Acceptance at edge N gives done=1 during cycle N+3.
  - The next instruction can be accepted in cycle N+4 at the earliest.
  - Throughput is one instruction per 4 cycles.
- Output holding: A_bus, B_bus and op hold their values outside OPERAND updates. result and z_flag hold until the next EXECUTE.
- Load port:
  - ld_en is honoured in any state. The write takes effect at the end of the cycle.
  - A load in the OPERAND cycle to ra or rb is not visible to that instruction; the old value is read.
  - A load and a writeback to the same index in the same cycle: writeback wins.
- Hazard: a back-to-back instruction reading the previous rd sees the written value, because writeback completes before the next accept.
- Widths: no width conversion. Index wrap is natural modulo NREGS.

Optional Feature:
- Macro: ALU_SEQ_IMM_EN.
- When defined:
  - Adds ports instr_imm_sel (in, 1) and instr_imm (in, 16).
  - If instr_imm_sel is latched as 1 at accept, B_bus is loaded with the sign-extended instr_imm instead of bank[rb]. rb is ignored.
- When undefined: the ports are absent and B_bus always comes from the bank.

Decomposition:
- Package alu_seq_pkg holds:
  - DATA_W and OP_W defaults;
  - the state encoding (IDLE=0, OPERAND=1, EXECUTE=2, WRITEBACK=3);
  - the ALU opcode constants shared with the ALU.
- Sub-module alu_seq_regfile:
  - two combinational read ports and one write port;
  - it performs the write-port arbitration (writeback over load) and enforces register 0.

Test Plan:
- Reset then idle: hold reset 2 cycles. Expect A_bus=B_bus=op=result=0, z_flag=0, done=0, instr_ready=1. Reading r1 through a no-op instruction returns 0.
- Basic op: load r1=32'hB, r2=32'h8, then issue op=4'b1100, ra=1, rb=2, rd=3.
  - EXECUTE: A_bus=0xB, B_bus=0x8, op=1100.
  - done in cycle 3 after accept, result equals the C_bus observed in EXECUTE.
  - A following instruction with ra=3 reads that value.
- Back-to-back: hold instr_valid high with ops 1011 then 1010. instr_ready is low for 3 cycles between accepts. Two done pulses, 4 cycles apart.
- Zero flag and r0: issue rd=0 with inputs giving C_bus=0. z_flag=1, done pulses, and r0 still reads 0.
- Collision: in the WRITEBACK cycle of rd=5, assert ld_en with ld_addr=5, ld_data=32'hDEAD. r5 holds the ALU result, not 32'hDEAD.
- Reset mid-op: assert reset during EXECUTE. No done pulse, rd unchanged, state IDLE the next cycle.
- With ALU_SEQ_IMM_EN: instr_imm_sel=1, instr_imm=16'hFFFE gives B_bus=32'hFFFFFFFE.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer: default widths, FSM encoding
// and the opcode constants the downstream ALU decodes.
package alu_seq_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 4;
  localparam int IMM_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_OPERAND   = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } seq_state_e;

  localparam logic [3:0] ALU_ADD = 4'b1010;
  localparam logic [3:0] ALU_SUB = 4'b1011;
  localparam logic [3:0] ALU_AND = 4'b1100;
  localparam logic [3:0] ALU_OR  = 4'b1101;
  localparam logic [3:0] ALU_XOR = 4'b1110;

endpackage

// File: rtl/alu_seq_regfile.sv
// Register bank for the sequencer: two combinational read ports, one arbitrated
// write path (writeback beats an external load to the same index); r0 reads zero.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = 8,
  parameter int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RA_W-1:0]   ra_addr_i,
  input  logic [RA_W-1:0]   rb_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic              wb_en_i,
  input  logic [RA_W-1:0]   wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              ld_en_i,
  input  logic [RA_W-1:0]   ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i
);

  logic [DATA_W-1:0] mem_q [NREGS];

  assign ra_data_o = (ra_addr_i == '0) ? '0 : mem_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == '0) ? '0 : mem_q[rb_addr_i];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wb_en_i && (wb_addr_i == RA_W'(i))) begin
          mem_q[i] <= wb_data_i;
        end else if (ld_en_i && (ld_addr_i == RA_W'(i))) begin
          mem_q[i] <= ld_data_i;
        end
      end
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Issue stage for the combinational ALU: IDLE -> OPERAND -> EXECUTE -> WRITEBACK,
// one instruction in flight. Define ALU_SEQ_IMM_EN to add a sign-extended B immediate.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int NREGS  = 8,
  parameter int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [RA_W-1:0]   instr_ra,
  input  logic [RA_W-1:0]   instr_rb,
  input  logic [RA_W-1:0]   instr_rd,
`ifdef ALU_SEQ_IMM_EN
  input  logic              instr_imm_sel,
  input  logic [IMM_W-1:0]  instr_imm,
`endif
  input  logic              ld_en,
  input  logic [RA_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] A_bus,
  output logic [DATA_W-1:0] B_bus,
  output logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] C_bus,
  input  logic              Z,
  output logic [DATA_W-1:0] result,
  output logic              z_flag,
  output logic              done
);

  seq_state_e        state_q, state_d;
  logic [OP_W-1:0]   op_lat_q;
  logic [RA_W-1:0]   ra_q, rb_q, rd_q;
  logic [DATA_W-1:0] a_q, b_q, result_q;
  logic [OP_W-1:0]   op_q;
  logic              zf_q;
  logic [DATA_W-1:0] rd_a, rd_b, b_src;
  logic              accept;

`ifdef ALU_SEQ_IMM_EN
  logic              imm_sel_q;
  logic [IMM_W-1:0]  imm_q;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  assign b_src = imm_sel_q ? sext_imm(imm_q) : rd_b;
`else
  assign b_src = rd_b;
`endif

  assign accept      = instr_valid && (state_q == ST_IDLE);
  assign instr_ready = (state_q == ST_IDLE);
  assign done        = (state_q == ST_WRITEBACK);
  assign A_bus       = a_q;
  assign B_bus       = b_q;
  assign op          = op_q;
  assign result      = result_q;
  assign z_flag      = zf_q;

  alu_seq_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .RA_W   (RA_W)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .ra_addr_i (ra_q),
    .rb_addr_i (rb_q),
    .ra_data_o (rd_a),
    .rb_data_o (rd_b),
    .wb_en_i   (state_q == ST_WRITEBACK),
    .wb_addr_i (rd_q),
    .wb_data_i (result_q),
    .ld_en_i   (ld_en),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (accept) state_d = ST_OPERAND;
      ST_OPERAND:   state_d = ST_EXECUTE;
      ST_EXECUTE:   state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_lat_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zf_q     <= 1'b0;
`ifdef ALU_SEQ_IMM_EN
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_lat_q <= instr_op;
        ra_q     <= instr_ra;
        rb_q     <= instr_rb;
        rd_q     <= instr_rd;
`ifdef ALU_SEQ_IMM_EN
        imm_sel_q <= instr_imm_sel;
        imm_q     <= instr_imm;
`endif
      end
      // Bank reads happen before any same-cycle load lands, so loads are invisible here.
      if (state_q == ST_OPERAND) begin
        a_q  <= rd_a;
        b_q  <= b_src;
        op_q <= op_lat_q;
      end
      if (state_q == ST_EXECUTE) begin
        result_q <= C_bus;
        zf_q     <= Z;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: behavioural ALU and register-bank model, directed
// scenarios plus randomized instructions. Covers the ALU_SEQ_IMM_EN path when defined.
module tb_alu_operand_sequencer;

  localparam int DW = 32;
  localparam int OW = 4;
  localparam int NR = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [OW-1:0] instr_op;
  logic [AW-1:0] instr_ra, instr_rb, instr_rd;
  logic          imm_sel;
  logic [15:0]   imm_val;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] A_bus, B_bus, C_bus, result;
  logic [OW-1:0] op_bus;
  logic          Z, z_flag, done;

  logic [DW-1:0] model [NR];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_ref(input logic [OW-1:0] f, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (f)
      4'b1010: return a + b;
      4'b1011: return a - b;
      4'b1100: return a & b;
      4'b1101: return a | b;
      4'b1110: return a ^ b;
      default: return a;
    endcase
  endfunction

  assign C_bus = alu_ref(op_bus, A_bus, B_bus);
  assign Z     = (C_bus == '0);

  alu_operand_sequencer #(.DATA_W(DW), .OP_W(OW), .NREGS(NR), .RA_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_ra    (instr_ra),
    .instr_rb    (instr_rb),
    .instr_rd    (instr_rd),
`ifdef ALU_SEQ_IMM_EN
    .instr_imm_sel (imm_sel),
    .instr_imm     (imm_val),
`endif
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .A_bus       (A_bus),
    .B_bus       (B_bus),
    .op          (op_bus),
    .C_bus       (C_bus),
    .Z           (Z),
    .result      (result),
    .z_flag      (z_flag),
    .done        (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    if (a != 0) model[a] = d;
  endtask

  // ldph: 0 none, 1 load to ra during OPERAND, 2 load to rd during WRITEBACK
  task automatic run_instr(input logic [OW-1:0] f, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                           input logic [AW-1:0] rd, input int ldph, input logic [DW-1:0] ldv,
                           input logic isel, input logic [15:0] imm);
    logic [DW-1:0] a_exp, b_exp, r_exp;
    chk("ready_idle", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1; instr_op = f; instr_ra = ra; instr_rb = rb; instr_rd = rd;
    imm_sel = isel; imm_val = imm;
    a_exp = model[ra];
    b_exp = isel ? {{16{imm[15]}}, imm} : model[rb];
    r_exp = alu_ref(f, a_exp, b_exp);
    tick();
    instr_valid = 1'b0; imm_sel = 1'b0;
    chk("ready_busy", 32'(instr_ready), 32'd0);
    if (ldph == 1) begin ld_en = 1'b1; ld_addr = ra; ld_data = ldv; end
    tick();
    ld_en = 1'b0;
    if (ldph == 1 && ra != 0) model[ra] = ldv;
    chk("a_bus", A_bus, a_exp);
    chk("b_bus", B_bus, b_exp);
    chk("op", 32'(op_bus), 32'(f));
    chk("done_exec", 32'(done), 32'd0);
    tick();
    chk("done_wb", 32'(done), 32'd1);
    chk("result", result, r_exp);
    chk("z_flag", 32'(z_flag), 32'(r_exp == '0));
    if (ldph == 2) begin ld_en = 1'b1; ld_addr = rd; ld_data = ldv; end
    tick();
    ld_en = 1'b0;
    if (ldph == 2 && rd != 0) model[rd] = ldv;
    if (rd != 0) model[rd] = r_exp;
    chk("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    logic [OW-1:0] ops [5];
    logic [DW-1:0] e1, e2;
    ops[0] = 4'b1010; ops[1] = 4'b1011; ops[2] = 4'b1100; ops[3] = 4'b1101; ops[4] = 4'b1110;
    reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_ra = '0; instr_rb = '0; instr_rd = '0;
    imm_sel = 1'b0; imm_val = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    // reset then idle
    tick(); tick();
    chk("rst_a", A_bus, 0); chk("rst_b", B_bus, 0); chk("rst_op", 32'(op_bus), 0);
    chk("rst_result", result, 0); chk("rst_z", 32'(z_flag), 0);
    chk("rst_done", 32'(done), 0); chk("rst_ready", 32'(instr_ready), 1);
    reset = 1'b0;
    tick();
    run_instr(4'b1010, 3'd1, 3'd1, 3'd0, 0, '0, 1'b0, '0);

    // basic op and dependent read
    do_load(3'd1, 32'hB);
    do_load(3'd2, 32'h8);
    run_instr(4'b1100, 3'd1, 3'd2, 3'd3, 0, '0, 1'b0, '0);
    chk("r3_value", model[3], 32'h8);
    run_instr(4'b1010, 3'd3, 3'd1, 3'd5, 0, '0, 1'b0, '0);

    // back-to-back with valid held high
    instr_valid = 1'b1; instr_op = 4'b1011; instr_ra = 3'd1; instr_rb = 3'd2; instr_rd = 3'd3;
    e1 = alu_ref(4'b1011, model[1], model[2]);
    tick();
    instr_op = 4'b1010; instr_ra = 3'd3; instr_rb = 3'd1; instr_rd = 3'd4;
    chk("b2b_ready1", 32'(instr_ready), 0);
    tick();
    chk("b2b_ready2", 32'(instr_ready), 0);
    tick();
    chk("b2b_ready3", 32'(instr_ready), 0);
    chk("b2b_done1", 32'(done), 1);
    chk("b2b_result1", result, e1);
    model[3] = e1;
    e2 = alu_ref(4'b1010, model[3], model[1]);
    tick();
    chk("b2b_ready_gap", 32'(instr_ready), 1);
    chk("b2b_done_gap", 32'(done), 0);
    tick();
    instr_valid = 1'b0;
    chk("b2b_ready5", 32'(instr_ready), 0);
    tick();
    chk("b2b_a_hazard", A_bus, e1);
    tick();
    chk("b2b_done2", 32'(done), 1);
    chk("b2b_result2", result, e2);
    model[4] = e2;
    tick();
    chk("b2b_done_clear", 32'(done), 0);

    // zero flag and r0 discard
    run_instr(4'b1011, 3'd1, 3'd1, 3'd0, 0, '0, 1'b0, '0);
    run_instr(4'b1010, 3'd0, 3'd1, 3'd0, 0, '0, 1'b0, '0);
    do_load(3'd0, 32'h1234);
    run_instr(4'b1101, 3'd0, 3'd0, 3'd2, 0, '0, 1'b0, '0);

    // load/writeback collision and load hidden from OPERAND read
    do_load(3'd2, 32'h8);
    run_instr(4'b1101, 3'd1, 3'd2, 3'd5, 2, 32'hDEAD, 1'b0, '0);
    run_instr(4'b1010, 3'd5, 3'd0, 3'd0, 0, '0, 1'b0, '0);
    run_instr(4'b1010, 3'd6, 3'd1, 3'd7, 1, 32'h55AA, 1'b0, '0);

    // randomized instructions
    for (int r = 0; r < NR; r++) do_load(AW'(r), $urandom);
    for (int n = 0; n < 24; n++) begin
      run_instr(ops[$urandom_range(0, 4)], AW'($urandom_range(0, NR-1)), AW'($urandom_range(0, NR-1)),
                AW'($urandom_range(0, NR-1)), int'($urandom_range(0, 2)), $urandom, 1'b0, '0);
    end

`ifdef ALU_SEQ_IMM_EN
    run_instr(4'b1010, 3'd1, 3'd3, 3'd2, 0, '0, 1'b1, 16'hFFFE);
    chk("imm_b_bus", model[2] - model[1], 32'hFFFFFFFE);
    run_instr(4'b1101, 3'd0, 3'd3, 3'd0, 0, '0, 1'b1, 16'h7FFF);
`endif

    // reset during EXECUTE abandons the instruction
    do_load(3'd6, 32'h600D);
    instr_valid = 1'b1; instr_op = 4'b1101; instr_ra = 3'd1; instr_rb = 3'd2; instr_rd = 3'd6;
    tick();
    instr_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    chk("midrst_ready", 32'(instr_ready), 1);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_result", result, 0);
    chk("midrst_a", A_bus, 0);
    tick();
    chk("midrst_no_done", 32'(done), 0);
    run_instr(4'b1010, 3'd6, 3'd0, 3'd0, 0, '0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
